// File: rtl/i2s_top_tx.sv
// I2S master transmitter: per-channel holding registers are serialised MSB-first
// onto sdat_o, with the bit clock and word select derived from clk_i.
module i2s_top_tx #(
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [WORD_WIDTH-1:0] data_i,
    input  logic                  lr_chnl_i,
    input  logic                  write_i,
    output logic                  req_o,
    output logic                  req_chnl_o,
    output logic                  underrun_o,
    output logic                  sclk_o,
    output logic                  wsel_o,
    output logic                  sdat_o
);
    localparam int PW = $clog2(2 * WORD_WIDTH);
    localparam logic [PW-1:0] P_ZERO      = {PW{1'b0}};
    localparam logic [PW-1:0] P_ONE       = PW'(1);
    localparam logic [PW-1:0] P_LOAD_L    = PW'(1);
    localparam logic [PW-1:0] P_SHIFT_L   = PW'(2);
    localparam logic [PW-1:0] P_RIGHT     = PW'(WORD_WIDTH);
    localparam logic [PW-1:0] P_LOAD_R    = PW'(WORD_WIDTH + 1);
    localparam logic [PW-1:0] P_LAST      = PW'(2 * WORD_WIDTH - 1);

    logic                  sclk_r, wsel_r, sdat_r, req_r, req_chnl_r, underrun_r;
    logic [PW-1:0]         slot_cnt_r;
    logic [WORD_WIDTH-1:0] hold_left_r, hold_right_r, shift_left_r, shift_right_r;
    logic                  valid_left_r, valid_right_r;

    logic                  ld_left_s, ld_right_s, sh_left_s, sh_right_s;
    logic                  wsel_next_s, sdat_next_s, req_next_s, req_chnl_next_s, underrun_next_s;
    logic [PW-1:0]         slot_cnt_next_s;
    logic [WORD_WIDTH-1:0] hold_left_next_s, hold_right_next_s;
    logic [WORD_WIDTH-1:0] shift_left_next_s, shift_right_next_s;
    logic                  valid_left_next_s, valid_right_next_s;

    // Slot decode: a slot is the edge on which sclk falls, i.e. while sclk_r is high
    always_comb begin
        ld_left_s  = 1'b0;
        ld_right_s = 1'b0;
        sh_left_s  = 1'b0;
        sh_right_s = 1'b0;
        if (sclk_r) begin
            ld_left_s  = (slot_cnt_r == P_LOAD_L);
            ld_right_s = (slot_cnt_r == P_LOAD_R);
            sh_left_s  = (slot_cnt_r >= P_SHIFT_L) && (slot_cnt_r <= P_RIGHT);
            sh_right_s = (slot_cnt_r > P_LOAD_R) || (slot_cnt_r == P_ZERO);
        end else begin
            ld_left_s  = 1'b0;
            ld_right_s = 1'b0;
            sh_left_s  = 1'b0;
            sh_right_s = 1'b0;
        end
    end

    // Serial side next state: slot counter, word select, shifters, data bit, request pulses
    always_comb begin
        slot_cnt_next_s    = slot_cnt_r;
        wsel_next_s        = wsel_r;
        sdat_next_s        = sdat_r;
        shift_left_next_s  = shift_left_r;
        shift_right_next_s = shift_right_r;
        req_next_s         = 1'b0;
        req_chnl_next_s    = 1'b0;
        underrun_next_s    = 1'b0;
        if (sclk_r) begin
            wsel_next_s = (slot_cnt_r >= P_RIGHT);
            if (slot_cnt_r == P_LAST) begin
                slot_cnt_next_s = P_ZERO;
            end else begin
                slot_cnt_next_s = slot_cnt_r + P_ONE;
            end
        end else begin
            slot_cnt_next_s = slot_cnt_r;
        end
        if (ld_left_s) begin
            shift_left_next_s = hold_left_r;
            sdat_next_s       = hold_left_r[WORD_WIDTH-1];
            req_next_s        = 1'b1;
            req_chnl_next_s   = 1'b0;
            underrun_next_s   = ~valid_left_r;
        end else if (ld_right_s) begin
            shift_right_next_s = hold_right_r;
            sdat_next_s        = hold_right_r[WORD_WIDTH-1];
            req_next_s         = 1'b1;
            req_chnl_next_s    = 1'b1;
            underrun_next_s    = ~valid_right_r;
        end else if (sh_left_s) begin
            shift_left_next_s = {shift_left_r[WORD_WIDTH-2:0], 1'b0};
            sdat_next_s       = shift_left_r[WORD_WIDTH-2];
        end else if (sh_right_s) begin
            shift_right_next_s = {shift_right_r[WORD_WIDTH-2:0], 1'b0};
            sdat_next_s        = shift_right_r[WORD_WIDTH-2];
        end else begin
            sdat_next_s = sdat_r;
        end
    end

    // Holding registers: a load clears valid, a same-cycle write to that channel re-arms it
    always_comb begin
        hold_left_next_s   = hold_left_r;
        hold_right_next_s  = hold_right_r;
        valid_left_next_s  = valid_left_r;
        valid_right_next_s = valid_right_r;
        if (ld_left_s) begin
            valid_left_next_s = 1'b0;
        end else begin
            valid_left_next_s = valid_left_r;
        end
        if (ld_right_s) begin
            valid_right_next_s = 1'b0;
        end else begin
            valid_right_next_s = valid_right_r;
        end
        if (write_i) begin
            if (lr_chnl_i) begin
                hold_right_next_s  = data_i;
                valid_right_next_s = 1'b1;
            end else begin
                hold_left_next_s  = data_i;
                valid_left_next_s = 1'b1;
            end
        end else begin
            hold_left_next_s  = hold_left_r;
            hold_right_next_s = hold_right_r;
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sclk_r        <= 1'b0;
            wsel_r        <= 1'b0;
            sdat_r        <= 1'b0;
            req_r         <= 1'b0;
            req_chnl_r    <= 1'b0;
            underrun_r    <= 1'b0;
            slot_cnt_r    <= P_ZERO;
            hold_left_r   <= {WORD_WIDTH{1'b0}};
            hold_right_r  <= {WORD_WIDTH{1'b0}};
            shift_left_r  <= {WORD_WIDTH{1'b0}};
            shift_right_r <= {WORD_WIDTH{1'b0}};
            valid_left_r  <= 1'b0;
            valid_right_r <= 1'b0;
        end else begin
            sclk_r        <= ~sclk_r;
            wsel_r        <= wsel_next_s;
            sdat_r        <= sdat_next_s;
            req_r         <= req_next_s;
            req_chnl_r    <= req_chnl_next_s;
            underrun_r    <= underrun_next_s;
            slot_cnt_r    <= slot_cnt_next_s;
            hold_left_r   <= hold_left_next_s;
            hold_right_r  <= hold_right_next_s;
            shift_left_r  <= shift_left_next_s;
            shift_right_r <= shift_right_next_s;
            valid_left_r  <= valid_left_next_s;
            valid_right_r <= valid_right_next_s;
        end
    end

    assign sclk_o     = sclk_r;
    assign wsel_o     = wsel_r;
    assign sdat_o     = sdat_r;
    assign req_o      = req_r;
    assign req_chnl_o = req_chnl_r;
    assign underrun_o = underrun_r;

endmodule

// File: tb/tb_i2s_top_tx.sv
// Self-checking bench for i2s_top_tx: slot-indexed reference model plus a
// behavioural I2S receiver that decodes the serial line back into words.
module tb_i2s_top_tx;
    localparam int W     = 16;
    localparam int FRAME = 4 * W;

    logic         clk_i     = 1'b0;
    logic         rst_i     = 1'b0;
    logic         write_i   = 1'b0;
    logic         lr_chnl_i = 1'b0;
    logic [W-1:0] data_i    = '0;
    logic         req_o, req_chnl_o, underrun_o, sclk_o, wsel_o, sdat_o;

    i2s_top_tx #(.WORD_WIDTH(W)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .data_i     (data_i),
        .lr_chnl_i  (lr_chnl_i),
        .write_i    (write_i),
        .req_o      (req_o),
        .req_chnl_o (req_chnl_o),
        .underrun_o (underrun_o),
        .sclk_o     (sclk_o),
        .wsel_o     (wsel_o),
        .sdat_o     (sdat_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: k = rising edges since reset release
    int           k = 0;
    logic [W-1:0] hold  [2];
    logic         valid [2];
    logic [W-1:0] word  [2];
    logic         e_sclk = 1'b0, e_wsel = 1'b0, e_sdat = 1'b0;
    logic         e_req = 1'b0, e_chnl = 1'b0, e_und = 1'b0;

    // Behavioural receiver: samples the DUT line on sclk rising edges
    logic         prev_sclk = 1'b0, rx_wsel = 1'b0;
    logic [W-1:0] rx_sr = '0;
    logic [W-1:0] rx_data [$];
    logic         rx_ch   [$];
    logic [W-1:0] exp_l [$];
    logic [W-1:0] exp_r [$];

    task automatic step(input logic rst, input logic wr, input logic ch, input logic [W-1:0] d);
        int p;
        int c;
        rst_i = rst; write_i = wr; lr_chnl_i = ch; data_i = d;
        @(posedge clk_i);
        if (!rst) begin
            k = 0;
            for (int i = 0; i < 2; i++) begin
                hold[i] = '0; valid[i] = 1'b0; word[i] = '0;
            end
            {e_sclk, e_wsel, e_sdat, e_req, e_chnl, e_und} = 6'b0;
        end else begin
            k++;
            e_sclk = (k % 2 == 1);
            e_req = 1'b0; e_chnl = 1'b0; e_und = 1'b0;
            if (k % 2 == 0) begin
                p = (k / 2 - 1) % (2 * W);
                e_wsel = (p >= W);
                if (p == 1 || p == W + 1) begin
                    c = (p == 1) ? 0 : 1;
                    word[c]  = hold[c];
                    e_und    = ~valid[c];
                    valid[c] = 1'b0;
                    e_req    = 1'b1;
                    e_chnl   = (c == 1);
                end
                if (p == 0)      e_sdat = word[1][0];
                else if (p <= W) e_sdat = word[0][W - p];
                else             e_sdat = word[1][2 * W - p];
            end
            if (wr) begin
                hold[ch] = d; valid[ch] = 1'b1;
            end
        end
        #1;
        if (!rst) begin
            prev_sclk = 1'b0; rx_wsel = 1'b0; rx_sr = '0;
        end else begin
            if (sclk_o === 1'b1 && prev_sclk === 1'b0) begin
                if (wsel_o !== rx_wsel) begin
                    rx_data.push_back({rx_sr[W-2:0], sdat_o});
                    rx_ch.push_back(rx_wsel);
                end
                rx_sr   = {rx_sr[W-2:0], sdat_o};
                rx_wsel = wsel_o;
            end
            prev_sclk = sclk_o;
        end
    endtask

    function automatic bit next_is_slot(input int p);
        return ((k + 1) % 2 == 0) && ((((k + 1) / 2 - 1) % (2 * W)) == p);
    endfunction

    task automatic clear_queues();
        rx_data.delete(); rx_ch.delete(); exp_l.delete(); exp_r.delete();
    endtask

    task automatic test_reset();
        int req_cnt = 0;
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        checks++;
        if ({sclk_o, wsel_o, sdat_o, req_o, req_chnl_o, underrun_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_state got %b expected 000000",
                     {sclk_o, wsel_o, sdat_o, req_o, req_chnl_o, underrun_o});
        end
        for (int i = 0; i < 3 * FRAME; i++) begin
            step(1'b1, 1'b0, 1'b0, '0);
            checks++;
            if ({sclk_o, wsel_o, sdat_o, req_o, req_chnl_o, underrun_o} !== {e_sclk, e_wsel, e_sdat, e_req, e_chnl, e_und}) begin
                errors++;
                $display("FAIL idle_outputs k=%0d got %b expected %b", k,
                         {sclk_o, wsel_o, sdat_o, req_o, req_chnl_o, underrun_o}, {e_sclk, e_wsel, e_sdat, e_req, e_chnl, e_und});
            end
            if (req_o === 1'b1) begin
                checks++;
                if (req_chnl_o !== 1'(req_cnt % 2) || underrun_o !== 1'b1) begin
                    errors++;
                    $display("FAIL idle_req_seq n=%0d got chnl=%b und=%b expected chnl=%0d und=1",
                             req_cnt, req_chnl_o, underrun_o, req_cnt % 2);
                end
                req_cnt++;
            end
        end
        checks++;
        if (req_cnt != 6) begin
            errors++;
            $display("FAIL idle_req_count got %0d expected 6", req_cnt);
        end
    endtask

    task automatic test_pattern();
        step(1'b0, 1'b0, 1'b0, '0);
        clear_queues();
        step(1'b1, 1'b1, 1'b0, 16'hA5C3);
        step(1'b1, 1'b1, 1'b1, 16'h5A3C);
        while (k < 67) begin
            step(1'b1, 1'b0, 1'b0, '0);
            checks++;
            if ({sclk_o, wsel_o, sdat_o, req_o, req_chnl_o, underrun_o} !== {e_sclk, e_wsel, e_sdat, e_req, e_chnl, e_und}) begin
                errors++;
                $display("FAIL pattern_outputs k=%0d got %b expected %b", k,
                         {sclk_o, wsel_o, sdat_o, req_o, req_chnl_o, underrun_o}, {e_sclk, e_wsel, e_sdat, e_req, e_chnl, e_und});
            end
            if (req_o === 1'b1) begin
                checks++;
                if (underrun_o !== 1'b0) begin
                    errors++;
                    $display("FAIL pattern_underrun chnl=%b got %b expected 0", req_chnl_o, underrun_o);
                end
            end
        end
        checks++;
        if (rx_data.size() < 2) begin
            errors++;
            $display("FAIL pattern_words got %0d words expected 2", rx_data.size());
        end else if (rx_data[0] !== 16'hA5C3 || rx_ch[0] !== 1'b0 || rx_data[1] !== 16'h5A3C || rx_ch[1] !== 1'b1) begin
            errors++;
            $display("FAIL pattern_words got %b:%h %b:%h expected 0:a5c3 1:5a3c",
                     rx_ch[0], rx_data[0], rx_ch[1], rx_data[1]);
        end
    endtask

    task automatic test_loopback();
        logic [W-1:0] d;
        logic pend = 1'b0, pend_ch = 1'b0;
        int cyc = 0;
        step(1'b0, 1'b0, 1'b0, '0);
        clear_queues();
        d = W'($urandom()); step(1'b1, 1'b1, 1'b0, d); exp_l.push_back(d);
        d = W'($urandom()); step(1'b1, 1'b1, 1'b1, d); exp_r.push_back(d);
        while (rx_data.size() < 20 && cyc < 16 * FRAME) begin
            if (pend) begin
                d = W'($urandom());
                step(1'b1, 1'b1, pend_ch, d);
                if (pend_ch) exp_r.push_back(d); else exp_l.push_back(d);
            end else begin
                step(1'b1, 1'b0, 1'b0, '0);
            end
            pend = e_req; pend_ch = e_chnl;
            cyc++;
            checks++;
            if ({sclk_o, wsel_o, sdat_o, req_o, req_chnl_o, underrun_o} !== {e_sclk, e_wsel, e_sdat, e_req, e_chnl, e_und}) begin
                errors++;
                $display("FAIL loopback_outputs k=%0d got %b expected %b", k,
                         {sclk_o, wsel_o, sdat_o, req_o, req_chnl_o, underrun_o}, {e_sclk, e_wsel, e_sdat, e_req, e_chnl, e_und});
            end
        end
        checks++;
        if (rx_data.size() < 20) begin
            errors++;
            $display("FAIL loopback_timeout got %0d words expected 20", rx_data.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                checks++;
                if (rx_ch[i] !== 1'(i % 2) || rx_data[i] !== ((i % 2 == 1) ? exp_r[i / 2] : exp_l[i / 2])) begin
                    errors++;
                    $display("FAIL loopback_word i=%0d got %b:%h expected %0d:%h", i, rx_ch[i], rx_data[i],
                             i % 2, (i % 2 == 1) ? exp_r[i / 2] : exp_l[i / 2]);
                end
            end
        end
    endtask

    task automatic test_left_only();
        logic [W-1:0] d;
        logic pend = 1'b0;
        int r_cnt = 0;
        int l_idx = 0;
        step(1'b0, 1'b0, 1'b0, '0);
        clear_queues();
        step(1'b1, 1'b1, 1'b1, 16'h1234);
        d = W'($urandom()); step(1'b1, 1'b1, 1'b0, d); exp_l.push_back(d);
        while (k < 5 * FRAME) begin
            if (pend) begin
                d = W'($urandom()); step(1'b1, 1'b1, 1'b0, d); exp_l.push_back(d);
            end else begin
                step(1'b1, 1'b0, 1'b0, '0);
            end
            pend = e_req && !e_chnl;
            checks++;
            if ({sclk_o, wsel_o, sdat_o, req_o, req_chnl_o, underrun_o} !== {e_sclk, e_wsel, e_sdat, e_req, e_chnl, e_und}) begin
                errors++;
                $display("FAIL left_only_outputs k=%0d got %b expected %b", k,
                         {sclk_o, wsel_o, sdat_o, req_o, req_chnl_o, underrun_o}, {e_sclk, e_wsel, e_sdat, e_req, e_chnl, e_und});
            end
            if (req_o === 1'b1) begin
                if (req_chnl_o === 1'b1) r_cnt++;
                checks++;
                if (underrun_o !== ((req_chnl_o === 1'b1) && (r_cnt > 1))) begin
                    errors++;
                    $display("FAIL left_only_underrun chnl=%b n=%0d got %b expected %b", req_chnl_o, r_cnt,
                             underrun_o, (req_chnl_o === 1'b1) && (r_cnt > 1));
                end
            end
        end
        for (int i = 0; i < rx_data.size(); i++) begin
            checks++;
            if (rx_ch[i] === 1'b1) begin
                if (rx_data[i] !== 16'h1234) begin
                    errors++;
                    $display("FAIL left_only_right_word i=%0d got %h expected 1234", i, rx_data[i]);
                end
            end else begin
                if (l_idx >= exp_l.size() || rx_data[i] !== exp_l[l_idx]) begin
                    errors++;
                    $display("FAIL left_only_left_word i=%0d got %h expected %h", i, rx_data[i],
                             (l_idx < exp_l.size()) ? exp_l[l_idx] : '0);
                end
                l_idx++;
            end
        end
    endtask

    task automatic test_write_on_load();
        logic [W-1:0] old_v = 16'hC0DE;
        logic [W-1:0] new_v = 16'h3E71;
        int l_req = 0;
        step(1'b0, 1'b0, 1'b0, '0);
        clear_queues();
        step(1'b1, 1'b1, 1'b0, old_v);
        step(1'b1, 1'b1, 1'b1, W'($urandom()));
        while (!next_is_slot(1)) step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, new_v);
        checks++;
        if (req_o !== 1'b1 || req_chnl_o !== 1'b0 || underrun_o !== 1'b0 || sdat_o !== old_v[W-1]) begin
            errors++;
            $display("FAIL wol_first_load got req=%b chnl=%b und=%b sdat=%b expected 1 0 0 %b",
                     req_o, req_chnl_o, underrun_o, sdat_o, old_v[W-1]);
        end
        while (k < 100) begin
            step(1'b1, 1'b0, 1'b0, '0);
            checks++;
            if ({sclk_o, wsel_o, sdat_o, req_o, req_chnl_o, underrun_o} !== {e_sclk, e_wsel, e_sdat, e_req, e_chnl, e_und}) begin
                errors++;
                $display("FAIL wol_outputs k=%0d got %b expected %b", k,
                         {sclk_o, wsel_o, sdat_o, req_o, req_chnl_o, underrun_o}, {e_sclk, e_wsel, e_sdat, e_req, e_chnl, e_und});
            end
            if (req_o === 1'b1 && req_chnl_o === 1'b0) begin
                l_req++;
                checks++;
                if (underrun_o !== 1'b0) begin
                    errors++;
                    $display("FAIL wol_second_underrun got %b expected 0", underrun_o);
                end
            end
        end
        checks++;
        if (rx_data.size() < 3 || rx_data[0] !== old_v || rx_data[2] !== new_v || l_req != 1) begin
            errors++;
            $display("FAIL wol_words got n=%0d l_req=%0d expected old %h then new %h", rx_data.size(), l_req, old_v, new_v);
        end
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] dl;
        logic [W-1:0] dr;
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, W'($urandom()));
        step(1'b1, 1'b1, 1'b1, W'($urandom()));
        while (!next_is_slot(7)) step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        checks++;
        if ({sclk_o, wsel_o, sdat_o, req_o, req_chnl_o, underrun_o} !== 6'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs got %b expected 000000",
                     {sclk_o, wsel_o, sdat_o, req_o, req_chnl_o, underrun_o});
        end
        clear_queues();
        dl = W'($urandom()) | 16'h8000;
        dr = W'($urandom());
        step(1'b1, 1'b1, 1'b0, dl);
        step(1'b1, 1'b1, 1'b1, dr);
        while (k < 67) begin
            step(1'b1, 1'b0, 1'b0, '0);
            checks++;
            if ({sclk_o, wsel_o, sdat_o, req_o, req_chnl_o, underrun_o} !== {e_sclk, e_wsel, e_sdat, e_req, e_chnl, e_und}) begin
                errors++;
                $display("FAIL mid_reset_outputs k=%0d got %b expected %b", k,
                         {sclk_o, wsel_o, sdat_o, req_o, req_chnl_o, underrun_o}, {e_sclk, e_wsel, e_sdat, e_req, e_chnl, e_und});
            end
            if (k == 4) begin
                checks++;
                if (wsel_o !== 1'b0 || sdat_o !== dl[W-1]) begin
                    errors++;
                    $display("FAIL mid_reset_first_msb got wsel=%b sdat=%b expected 0 %b", wsel_o, sdat_o, dl[W-1]);
                end
            end
        end
        checks++;
        if (rx_data.size() < 2 || rx_data[0] !== dl || rx_data[1] !== dr) begin
            errors++;
            $display("FAIL mid_reset_words got n=%0d expected %h %h", rx_data.size(), dl, dr);
        end
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_loopback();
        test_left_only();
        test_write_on_load();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
